// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the BCD counter array: digit constants,
// a signed carry type and the single-digit decimal add/ripple step.
package bcd_counter_pkg;

    localparam int          BCD_W    = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_ZERO = 4'd0;

    // Decimal carry/borrow between digits: -1, 0 or +1.
    typedef logic signed [1:0] carry_t;

    localparam carry_t CARRY_NONE = 2'sb00;
    localparam carry_t CARRY_UP   = 2'sb01;
    localparam carry_t CARRY_DOWN = 2'sb11;

    typedef struct packed {
        logic [3:0] digit;
        carry_t     cout;
    } digit_step_t;

    // One digit of the ripple: t = digit + d + cin lies in -2..11, so a
    // single +/-10 correction is always enough.
    function automatic digit_step_t bcd_digit_step(
        input logic [3:0] digit,
        input carry_t     d,
        input carry_t     cin
    );
        logic signed [4:0] t;
        digit_step_t       r;
        t = $signed({1'b0, digit}) + $signed({{3{d[1]}}, d}) + $signed({{3{cin[1]}}, cin});
        if (t > 5'sd9) begin
            r.digit = 4'(t - 5'sd10);
            r.cout  = CARRY_UP;
        end else if (t < 5'sd0) begin
            r.digit = 4'(t + 5'sd10);
            r.cout  = CARRY_DOWN;
        end else begin
            r.digit = t[3:0];
            r.cout  = CARRY_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_array_switch_conditioner.sv
// Switch conditioner: three-stage tick-enabled sampler on a raw switch.
// EDGE_MODE=1 gives a one-cycle rising-edge pulse (valid in a tick cycle),
// EDGE_MODE=0 gives the synchronised level.
module switch_conditioner #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic out
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Shift the sampler only on sample ticks; otherwise hold.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (tick) begin
            s1_d = raw;
            s2_d = s1_q;
            s3_d = s2_q;
        end
    end

    // Sampler registers, cleared by reset so release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out = EDGE_MODE ? (tick & s2_q & ~s3_q) : s2_q;

endmodule

// File: rtl/bcd_counter_array.sv
// N-digit BCD up/down counter with per-digit inc/dec switches and global
// set-max / set-zero buttons. Carries ripple across all digits in one cycle;
// out-of-range results saturate (SATURATE=1) or wrap modulo 10^NDIG.
// Optional digit-scan outputs are built when BCD_COUNTER_ARRAY_SCAN_EN is
// defined; otherwise an_n is all ones and scan_bcd is zero.
module bcd_counter_array
    import bcd_counter_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int SATURATE   = 1,
    parameter int SCAN_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [NDIG-1:0]       inc_raw,
    input  logic [NDIG-1:0]       dec_raw,
    input  logic                  set_max_raw,
    input  logic                  set_zero_raw,
    output logic [BCD_W*NDIG-1:0] digits,
    output logic                  ovf,
    output logic                  unf,
    output logic [NDIG-1:0]       an_n,
    output logic [3:0]            scan_bcd
);

    if (NDIG < 1 || NDIG > 8) begin : g_bad_ndig
        $error("bcd_counter_array: NDIG must be 1..8");
    end
    if (SCAN_TICKS < 1) begin : g_bad_scan
        $error("bcd_counter_array: SCAN_TICKS must be >= 1");
    end

    logic [BCD_W*NDIG-1:0] digits_q, digits_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [NDIG-1:0]       inc_p;
    logic [NDIG-1:0]       dec_p;
    logic                  set_max_lvl;
    logic                  set_zero_lvl;
    logic [BCD_W*NDIG-1:0] sum_c;
    carry_t                final_carry;
    logic                  any_pulse;

    switch_conditioner #(.EDGE_MODE(1'b0)) u_set_max (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .raw   (set_max_raw),
        .out   (set_max_lvl)
    );

    switch_conditioner #(.EDGE_MODE(1'b0)) u_set_zero (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .raw   (set_zero_raw),
        .out   (set_zero_lvl)
    );

    genvar gi;
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
        carry_t      delta_w;
        carry_t      cin_w;
        carry_t      cout_w;
        digit_step_t step_w;

        switch_conditioner #(.EDGE_MODE(1'b1)) u_inc (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (inc_raw[gi]),
            .out   (inc_p[gi])
        );

        switch_conditioner #(.EDGE_MODE(1'b1)) u_dec (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (dec_raw[gi]),
            .out   (dec_p[gi])
        );

        // Simultaneous inc and dec on one digit cancel out.
        assign delta_w = (inc_p[gi] == dec_p[gi]) ? CARRY_NONE :
                         (inc_p[gi] ? CARRY_UP : CARRY_DOWN);

        if (gi == 0) begin : g_lsd
            assign cin_w = CARRY_NONE;
        end else begin : g_upper
            assign cin_w = g_digit[gi-1].cout_w;
        end

        assign step_w = bcd_digit_step(digits_q[BCD_W*gi +: BCD_W], delta_w, cin_w);
        assign sum_c[BCD_W*gi +: BCD_W] = step_w.digit;
        assign cout_w = step_w.cout;
    end

    assign final_carry = g_digit[NDIG-1].cout_w;
    assign any_pulse   = (|inc_p) | (|dec_p);

    // Next counter value: set_zero beats set_max beats arithmetic.
    always_comb begin
        digits_d = digits_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (set_zero_lvl) begin
            digits_d = {NDIG{BCD_ZERO}};
        end else if (set_max_lvl) begin
            digits_d = {NDIG{BCD_MAX}};
        end else if (any_pulse) begin
            digits_d = sum_c;
            if (final_carry == CARRY_UP) begin
                ovf_d = 1'b1;
                if (SATURATE != 0) begin
                    digits_d = {NDIG{BCD_MAX}};
                end
            end else if (final_carry == CARRY_DOWN) begin
                unf_d = 1'b1;
                if (SATURATE != 0) begin
                    digits_d = {NDIG{BCD_ZERO}};
                end
            end
        end
    end

    // Counter state and overflow/underflow pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign digits = digits_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

`ifdef BCD_COUNTER_ARRAY_SCAN_EN
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [NDIG-1:0]  an_n_q, an_n_d;
    logic [3:0]       scan_bcd_q, scan_bcd_d;

    // Dwell SCAN_TICKS ticks per digit, then step to the next digit.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        scan_idx_d = scan_idx_q;
        if (tick) begin
            if (scan_cnt_q == CNT_W'(SCAN_TICKS - 1)) begin
                scan_cnt_d = '0;
                scan_idx_d = (scan_idx_q == IDX_W'(NDIG - 1)) ? '0 : scan_idx_q + 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end
        an_n_d     = '1;
        scan_bcd_d = BCD_ZERO;
        for (int i = 0; i < NDIG; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                an_n_d[i]  = 1'b0;
                scan_bcd_d = digits_q[BCD_W*i +: BCD_W];
            end
        end
    end

    // Scan counter and registered digit-select / digit-value outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            an_n_q     <= '1;
            scan_bcd_q <= BCD_ZERO;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            an_n_q     <= an_n_d;
            scan_bcd_q <= scan_bcd_d;
        end
    end

    assign an_n     = an_n_q;
    assign scan_bcd = scan_bcd_q;
`else
    assign an_n     = '1;
    assign scan_bcd = BCD_ZERO;
`endif

endmodule

// File: tb/tb_bcd_counter_array.sv
// Testbench for bcd_counter_array (NDIG=4). The reference keeps the counter
// as a plain integer and the raw inputs as a per-tick sample history.
module tb_bcd_counter_array;

    localparam int NDIG = 4;
    localparam int SAT  = 1;
    localparam int SCNT = 2;
    localparam int MAXV = 9999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  inc_raw = '0;
    logic [3:0]  dec_raw = '0;
    logic        set_max_raw = 1'b0;
    logic        set_zero_raw = 1'b0;
    logic [15:0] digits;
    logic        ovf;
    logic        unf;
    logic [3:0]  an_n;
    logic [3:0]  scan_bcd;

    bcd_counter_array #(
        .NDIG       (NDIG),
        .SATURATE   (SAT),
        .SCAN_TICKS (SCNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .inc_raw      (inc_raw),
        .dec_raw      (dec_raw),
        .set_max_raw  (set_max_raw),
        .set_zero_raw (set_zero_raw),
        .digits       (digits),
        .ovf          (ovf),
        .unf          (unf),
        .an_n         (an_n),
        .scan_bcd     (scan_bcd)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    int         m_val = 0;
    bit         m_ovf, m_unf;
    logic [3:0] h_inc [3];
    logic [3:0] h_dec [3];
    bit         h_mx  [3];
    bit         h_zr  [3];
    int         m_idx = 0;
    int         m_cnt = 0;
    logic [3:0] exp_an;
    logic [3:0] exp_scan;
    bit         seen_ovf, seen_unf;
    int         pw [4] = '{1, 10, 100, 1000};

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_val = 0;
        m_idx = 0;
        m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            h_inc[i] = '0;
            h_dec[i] = '0;
            h_mx[i]  = 1'b0;
            h_zr[i]  = 1'b0;
        end
    endtask

    // One clock edge with the given tick value; model then compare.
    task automatic cycle(input bit t);
        int         delta, nv;
        logic [15:0] before_bcd;
        tick = t;
        @(posedge clk);
        before_bcd = to_bcd(m_val);
`ifdef BCD_COUNTER_ARRAY_SCAN_EN
        exp_an   = ~(4'b0001 << m_idx);
        exp_scan = before_bcd[4*m_idx +: 4];
`else
        exp_an   = 4'hF;
        exp_scan = 4'h0;
`endif
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (h_zr[1]) begin
            m_val = 0;
        end else if (h_mx[1]) begin
            m_val = MAXV;
        end else if (t) begin
            delta = 0;
            for (int i = 0; i < 4; i++) begin
                if (h_inc[1][i] && !h_inc[2][i]) delta += pw[i];
                if (h_dec[1][i] && !h_dec[2][i]) delta -= pw[i];
            end
            nv = m_val + delta;
            if (nv > MAXV) begin
                m_ovf = 1'b1;
                m_val = (SAT != 0) ? MAXV : nv - (MAXV + 1);
            end else if (nv < 0) begin
                m_unf = 1'b1;
                m_val = (SAT != 0) ? 0 : nv + (MAXV + 1);
            end else begin
                m_val = nv;
            end
        end
        if (t) begin
            h_inc[2] = h_inc[1]; h_inc[1] = h_inc[0]; h_inc[0] = inc_raw;
            h_dec[2] = h_dec[1]; h_dec[1] = h_dec[0]; h_dec[0] = dec_raw;
            h_mx[2]  = h_mx[1];  h_mx[1]  = h_mx[0];  h_mx[0]  = set_max_raw;
            h_zr[2]  = h_zr[1];  h_zr[1]  = h_zr[0];  h_zr[0]  = set_zero_raw;
            m_cnt++;
            if (m_cnt == SCNT) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % NDIG;
            end
        end
        #1;
        chk("digits", 32'(digits), 32'(to_bcd(m_val)));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("unf", 32'(unf), 32'(m_unf));
        chk("an_n", 32'(an_n), 32'(exp_an));
        chk("scan_bcd", 32'(scan_bcd), 32'(exp_scan));
        if (ovf === 1'b1) seen_ovf = 1'b1;
        if (unf === 1'b1) seen_unf = 1'b1;
        $display("cyc tick=%0b inc=%b dec=%b mx=%0b zr=%0b digits=%h ovf=%0b unf=%0b an_n=%b scan=%h",
                 t, inc_raw, dec_raw, set_max_raw, set_zero_raw, digits, ovf, unf, an_n, scan_bcd);
    endtask

    // One sample tick followed by 0..2 idle clocks.
    task automatic tk();
        cycle(1'b1);
        repeat ($urandom_range(0, 2)) cycle(1'b0);
    endtask

    task automatic press(input logic [3:0] inc, input logic [3:0] dec);
        inc_raw = inc;
        dec_raw = dec;
        repeat (3) tk();
        inc_raw = '0;
        dec_raw = '0;
        repeat (3) tk();
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_unf", 32'(unf), 32'h0);
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_scan", 32'(scan_bcd), 32'h0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Ten increments on digit 0 -> 0010
        seen_ovf = 1'b0;
        repeat (10) press(4'b0001, 4'b0000);
        chk("plan_inc10", 32'(digits), 32'h0010);
        chk("plan_inc10_noovf", 32'(seen_ovf), 32'h0);

        // Underflow from zero
        do_reset();
        seen_unf = 1'b0;
        press(4'b0000, 4'b0001);
        chk("plan_unf_val", 32'(digits), (SAT != 0) ? 32'h0000 : 32'h9999);
        chk("plan_unf_pulse", 32'(seen_unf), 32'h1);

        // Load max, then overflow via digit 1
        set_max_raw = 1'b1;
        repeat (3) tk();
        set_max_raw = 1'b0;
        repeat (3) tk();
        chk("plan_setmax", 32'(digits), 32'h9999);
        seen_ovf = 1'b0;
        press(4'b0010, 4'b0000);
        chk("plan_ovf_val", 32'(digits), (SAT != 0) ? 32'h9999 : 32'h0009);
        chk("plan_ovf_pulse", 32'(seen_ovf), 32'h1);

        // 0509 + inc[0] + inc[2] in one tick -> 0610
        do_reset();
        repeat (5) press(4'b0100, 4'b0000);
        repeat (9) press(4'b0001, 4'b0000);
        chk("plan_0509", 32'(digits), 32'h0509);
        press(4'b0101, 4'b0000);
        chk("plan_0610", 32'(digits), 32'h0610);
        press(4'b0010, 4'b0010);
        chk("plan_cancel", 32'(digits), 32'h0610);

        // set_zero beats set_max; release zero -> max; reset mid-hold
        set_max_raw  = 1'b1;
        set_zero_raw = 1'b1;
        repeat (3) tk();
        cycle(1'b0);
        chk("plan_both_zero", 32'(digits), 32'h0000);
        set_zero_raw = 1'b0;
        tk();
        tk();
        cycle(1'b0);
        chk("plan_rel_zero", 32'(digits), 32'h9999);
        do_reset();
        cycle(1'b0);
        chk("plan_rst_hold", 32'(digits), 32'h0000);
        set_max_raw = 1'b0;
        repeat (4) tk();

        // Randomised phase against the reference model
        for (int n = 0; n < 200; n++) begin
            inc_raw      = 4'($urandom) & 4'($urandom);
            dec_raw      = 4'($urandom) & 4'($urandom);
            set_max_raw  = ($urandom_range(0, 29) == 0);
            set_zero_raw = ($urandom_range(0, 29) == 0);
            tk();
            if (n == 120) do_reset();
        end
        inc_raw      = '0;
        dec_raw      = '0;
        set_max_raw  = 1'b0;
        set_zero_raw = 1'b0;
        repeat (4) tk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
